// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC controller: owns the architectural PC, selects the next fetch address
// (sequential, branch, jump, exception) and parks redirects that arrive while fetch is held.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        exception,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] PC,
    output logic [31:0] PC_plus4,
    output logic        flush,
    output logic        redirect_pending
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic        pend_vld_q, pend_vld_d;
    logic        pend_exc_q, pend_exc_d;
    logic        imem_req_q, imem_req_d;

    logic        can_load_s;
    logic        new_redir_s;
    logic [31:0] new_tgt_s;
    logic [31:0] pc_plus4_s;
    logic        flush_s;

    // Redirect targets are always word aligned.
    function automatic logic [31:0] align_tgt(input logic [31:0] tgt);
        return {tgt[31:2], 2'b00};
    endfunction

    assign pc_plus4_s = pc_q + 32'd4;

    // Next-PC selection, pending-redirect bookkeeping and state transitions.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_tgt_d  = pend_tgt_q;
        pend_vld_d  = pend_vld_q;
        pend_exc_d  = pend_exc_q;
        flush_s     = 1'b0;
        new_redir_s = exception || branch_taken || jump;
        can_load_s  = (state_q != BOOT) && !stall && imem_ready;

        if (exception) begin
            new_tgt_s = EXC_VECTOR;
        end else if (branch_taken) begin
            new_tgt_s = align_tgt(branch_target);
        end else if (jump) begin
            new_tgt_s = align_tgt(jump_target);
        end else begin
            new_tgt_s = pc_plus4_s;
        end

        case (state_q)
            BOOT:        state_d = FETCH;
            FETCH, HOLD: state_d = can_load_s ? FETCH : HOLD;
            default:     state_d = BOOT;
        endcase

        if (can_load_s) begin
            if (new_redir_s) begin
                pc_d       = new_tgt_s;
                flush_s    = 1'b1;
                pend_vld_d = 1'b0;
                pend_exc_d = 1'b0;
            end else if (pend_vld_q) begin
                pc_d       = pend_tgt_q;
                flush_s    = 1'b1;
                pend_vld_d = 1'b0;
                pend_exc_d = 1'b0;
            end else begin
                pc_d = pc_plus4_s;
            end
        end else if (new_redir_s && (exception || !(pend_vld_q && pend_exc_q))) begin
            // A parked exception is never displaced by a younger branch or jump.
            pend_tgt_d = new_tgt_s;
            pend_vld_d = 1'b1;
            pend_exc_d = exception;
            flush_s    = 1'b1;
        end else begin
            pend_vld_d = pend_vld_q;
        end

        imem_req_d = (state_d != BOOT);
    end

    // State, PC, pending redirect and registered fetch request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            pend_tgt_q <= 32'h0000_0000;
            pend_vld_q <= 1'b0;
            pend_exc_q <= 1'b0;
            imem_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_tgt_q <= pend_tgt_d;
            pend_vld_q <= pend_vld_d;
            pend_exc_q <= pend_exc_d;
            imem_req_q <= imem_req_d;
        end
    end

    assign imem_req         = imem_req_q;
    assign PC               = pc_q;
    assign PC_plus4         = pc_plus4_s;
    assign flush            = flush_s;
    assign redirect_pending = pend_vld_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed, table-driven bench for pc_fetch_ctrl with hand-written reset sequences.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        exception;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] PC;
    logic [31:0] PC_plus4;
    logic        flush;
    logic        redirect_pending;

    int n_chk  = 0;
    int n_fail = 0;

    pc_fetch_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .jump             (jump),
        .jump_target      (jump_target),
        .exception        (exception),
        .imem_ready       (imem_ready),
        .imem_req         (imem_req),
        .PC               (PC),
        .PC_plus4         (PC_plus4),
        .flush            (flush),
        .redirect_pending (redirect_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] bt;
        logic        jmp;
        logic [31:0] jt;
        logic        exc;
        logic        rdy;
        logic        exp_flush;
        logic [31:0] exp_pc;
        logic        exp_pend;
        logic        exp_req;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic s, input logic b, input logic [31:0] bt,
                                input logic j, input logic [31:0] jt, input logic e,
                                input logic r, input logic ef, input logic [31:0] epc,
                                input logic ep, input logic eq);
        vec_t v;
        v.stall = s; v.br = b; v.bt = bt; v.jmp = j; v.jt = jt; v.exc = e; v.rdy = r;
        v.exp_flush = ef; v.exp_pc = epc; v.exp_pend = ep; v.exp_req = eq;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        jump = 1'b0; jump_target = 32'h0; exception = 1'b0; imem_ready = 1'b1;
    endtask

    logic [31:0] exp_cur;

    initial begin
        //            stall br bt            jmp jt            exc rdy flush exp_pc        pend req
        vecs[0]  = mk(1'b0, 1'b0, 32'h0,     1'b0, 32'h0,     1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
        vecs[1]  = mk(1'b0, 1'b0, 32'h0,     1'b0, 32'h0,     1'b0, 1'b1, 1'b0, 32'h0000_0004, 1'b0, 1'b1);
        vecs[2]  = mk(1'b0, 1'b0, 32'h0,     1'b0, 32'h0,     1'b0, 1'b1, 1'b0, 32'h0000_0008, 1'b0, 1'b1);
        vecs[3]  = mk(1'b0, 1'b0, 32'h0,     1'b0, 32'h0,     1'b0, 1'b1, 1'b0, 32'h0000_000C, 1'b0, 1'b1);
        vecs[4]  = mk(1'b0, 1'b0, 32'h0,     1'b0, 32'h0,     1'b0, 1'b1, 1'b0, 32'h0000_0010, 1'b0, 1'b1);
        vecs[5]  = mk(1'b0, 1'b1, 32'h103,   1'b0, 32'h0,     1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b0, 1'b1);
        vecs[6]  = mk(1'b0, 1'b0, 32'h0,     1'b0, 32'h0,     1'b0, 1'b1, 1'b0, 32'h0000_0104, 1'b0, 1'b1);
        vecs[7]  = mk(1'b1, 1'b1, 32'h200,   1'b0, 32'h0,     1'b0, 1'b1, 1'b1, 32'h0000_0104, 1'b1, 1'b1);
        vecs[8]  = mk(1'b1, 1'b0, 32'h0,     1'b0, 32'h0,     1'b0, 1'b1, 1'b0, 32'h0000_0104, 1'b1, 1'b1);
        vecs[9]  = mk(1'b1, 1'b0, 32'h0,     1'b0, 32'h0,     1'b0, 1'b1, 1'b0, 32'h0000_0104, 1'b1, 1'b1);
        vecs[10] = mk(1'b0, 1'b0, 32'h0,     1'b0, 32'h0,     1'b0, 1'b1, 1'b1, 32'h0000_0200, 1'b0, 1'b1);
        vecs[11] = mk(1'b1, 1'b0, 32'h0,     1'b1, 32'h300,   1'b0, 1'b1, 1'b1, 32'h0000_0200, 1'b1, 1'b1);
        vecs[12] = mk(1'b1, 1'b0, 32'h0,     1'b0, 32'h0,     1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b1, 1'b1);
        vecs[13] = mk(1'b1, 1'b1, 32'h400,   1'b0, 32'h0,     1'b0, 1'b1, 1'b0, 32'h0000_0200, 1'b1, 1'b1);
        vecs[14] = mk(1'b0, 1'b0, 32'h0,     1'b0, 32'h0,     1'b0, 1'b1, 1'b1, 32'h8000_0180, 1'b0, 1'b1);
        vecs[15] = mk(1'b0, 1'b0, 32'h0,     1'b0, 32'h0,     1'b0, 1'b1, 1'b0, 32'h8000_0184, 1'b0, 1'b1);
        vecs[16] = mk(1'b0, 1'b1, 32'h500,   1'b1, 32'h600,   1'b1, 1'b1, 1'b1, 32'h8000_0180, 1'b0, 1'b1);
        vecs[17] = mk(1'b0, 1'b0, 32'h0,     1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 32'h8000_0180, 1'b0, 1'b1);
        vecs[18] = mk(1'b0, 1'b0, 32'h0,     1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 32'h8000_0180, 1'b0, 1'b1);
        vecs[19] = mk(1'b0, 1'b0, 32'h0,     1'b0, 32'h0,     1'b0, 1'b1, 1'b0, 32'h8000_0184, 1'b0, 1'b1);
        vecs[20] = mk(1'b0, 1'b0, 32'h0,     1'b1, 32'h1002,  1'b0, 1'b1, 1'b1, 32'h0000_1000, 1'b0, 1'b1);
        vecs[21] = mk(1'b0, 1'b1, 32'h2000,  1'b1, 32'h3000,  1'b0, 1'b1, 1'b1, 32'h0000_2000, 1'b0, 1'b1);
        vecs[22] = mk(1'b0, 1'b0, 32'h0,     1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
        vecs[23] = mk(1'b0, 1'b0, 32'h0,     1'b0, 32'h0,     1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
        vecs[24] = mk(1'b0, 1'b0, 32'h0,     1'b0, 32'h0,     1'b0, 1'b1, 1'b0, 32'h0000_0004, 1'b0, 1'b1);
        vecs[25] = mk(1'b1, 1'b0, 32'h0,     1'b1, 32'h700,   1'b0, 1'b1, 1'b1, 32'h0000_0004, 1'b1, 1'b1);

        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        chk("rst_pc", PC, 32'h0000_0000);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_pend", {31'd0, redirect_pending}, 32'd0);
        chk("rst_pc_plus4", PC_plus4, 32'h0000_0004);

        reset = 1'b1;
        #1;
        chk("boot_req", {31'd0, imem_req}, 32'd0);
        exp_cur = 32'h0000_0000;

        for (int i = 0; i < NV; i++) begin
            stall = vecs[i].stall; branch_taken = vecs[i].br; branch_target = vecs[i].bt;
            jump = vecs[i].jmp; jump_target = vecs[i].jt; exception = vecs[i].exc;
            imem_ready = vecs[i].rdy;
            #1;
            chk($sformatf("v%0d_flush", i), {31'd0, flush}, {31'd0, vecs[i].exp_flush});
            chk($sformatf("v%0d_pc_plus4", i), PC_plus4, exp_cur + 32'd4);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_pc", i), PC, vecs[i].exp_pc);
            chk($sformatf("v%0d_pend", i), {31'd0, redirect_pending}, {31'd0, vecs[i].exp_pend});
            chk($sformatf("v%0d_req", i), {31'd0, imem_req}, {31'd0, vecs[i].exp_req});
            exp_cur = vecs[i].exp_pc;
            @(negedge clk);
        end

        // Reset pulse while held with a parked jump: everything returns to boot at once.
        reset = 1'b0;
        idle_inputs();
        #1;
        chk("mid_rst_pc", PC, 32'h0000_0000);
        chk("mid_rst_pend", {31'd0, redirect_pending}, 32'd0);
        chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        chk("mid_rst_flush", {31'd0, flush}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("reboot_req", {31'd0, imem_req}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("reboot_pc%0d", k), PC, 32'(k * 4));
            chk($sformatf("reboot_pend%0d", k), {31'd0, redirect_pending}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Fetch-stage program-counter controller: owns the architectural PC register and consumes the branch target produced by the branch-target adder (ImmShift + PC), plus jump and exception redirects. It selects the next PC, holds on hazard stalls or instruction-memory back-pressure, and latches redirects that arrive while fetch cannot advance. It sits between the EX-stage branch resolution logic and the instruction memory / IF-ID pipeline register.

## Interface

- RESET_PC, 32'h0000_0000, PC value loaded on reset
- EXC_VECTOR, 32'h8000_0180, PC loaded on exception redirect

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- stall  in  1  hazard unit hold; PC must not advance
- branch_taken  in  1  EX-stage branch resolved taken
- branch_target  in  32  branch target from branch-target adder
- jump  in  1  jump redirect valid
- jump_target  in  32  jump destination
- exception  in  1  exception redirect to EXC_VECTOR
- imem_ready  in  1  instruction memory accepts fetch this cycle
- imem_req  out  1  fetch request for address PC
- PC  out  32  current fetch address (registered)
- PC_plus4  out  32  PC + 4, combinational, wraps mod 2^32
- flush  out  1  squash IF/ID contents this cycle
- redirect_pending  out  1  a redirect is latched awaiting application

## Operation

- States: BOOT, FETCH, HOLD.
- BOOT: entered on reset; imem_req=0; next edge with reset high -> FETCH. PC stays RESET_PC.
- advance = (state==FETCH) && !stall && imem_ready.
- FETCH: imem_req=1. If !advance -> HOLD (PC held). Else PC loads next-PC.
- HOLD: imem_req=1 (request kept stable, same PC). When !stall && imem_ready -> FETCH, applying next-PC on that edge (PC updates on the HOLD->FETCH edge too).
- Next-PC priority: exception > branch_taken > jump > pending redirect > PC_plus4. Pending redirect is used only when no new redirect input is active.
- Redirect when fetch cannot advance: latched into pending register (target + kind); redirect_pending=1 from next cycle.
- Pending overwrite: new exception always overwrites; new branch/jump overwrites only if pending kind is not exception.
- Applying any redirect (new or pending) clears pending on the same edge.
- Target alignment: low 2 bits of every target forced to 2'b00.
- flush: combinational; 1 in any cycle where PC loads a redirect target at the coming edge, and also 1 in any cycle where a new redirect is latched into pending. 0 otherwise.
- Simultaneous stall and redirect: redirect latched, flush=1, PC held.

## Timing

- Reset (async, reset=0): PC=RESET_PC, state=BOOT, pending cleared, imem_req=0, flush=0, redirect_pending=0, PC_plus4=RESET_PC+4.
- Sequential fetch: one PC increment per advancing cycle; throughput 1 fetch/cycle when stall=0, imem_ready=1.
- Redirect latency: branch_taken high in cycle N with advance -> PC=branch_target at N+1.
- Latched redirect: applied on first advancing edge; PC = target one cycle after stall/imem_ready clear.
- Reset asserted mid-HOLD or with pending redirect: pending discarded, PC=RESET_PC immediately.
- PC 32'hFFFF_FFFC sequential -> 32'h0000_0000.

## Test plan

- Reset release, stall=0, imem_ready=1: cycle 0 BOOT imem_req=0; then PC 0x0, 0x4, 0x8 on successive cycles.
- PC=0x10, branch_taken=1, branch_target=0x0000_0103: flush=1, next PC=0x0000_0100.
- stall=1 while branch_taken=1 target 0x200, stall held 3 cycles: PC held, redirect_pending=1, PC=0x200 on edge after stall drops, pending cleared.
- Pending jump 0x300 then exception during stall: after stall clears PC=0x8000_0180; a later branch during stall does not overwrite pending exception.
- Simultaneous exception, branch_taken, jump in advancing cycle: PC=EXC_VECTOR; imem_ready=0 for 2 cycles holds PC with imem_req=1.
- reset pulsed low during HOLD with pending redirect: PC=RESET_PC asynchronously, redirect_pending=0, BOOT then sequential fetch from 0x0.
